mfp_ahb_lite_uart_console: RTL and testbench

//  AHB-Lite master that feeds the UART16550 AHB-Lite slave. After reset it programs the

---
 rtl/mfp_ahb_lite_uart_console.sv | 165 ++++++++++++++++
 tb/tb_mfp_ahb_lite_uart_console.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_lite_uart_console.sv
// AHB-Lite master that programs a UART16550 after reset and then streams bytes from
// a local FIFO into THR, polling LSR.THRE before each burst of up to TX_BURST writes.
module mfp_ahb_lite_uart_console #(
  parameter logic [31:0] UART_BASE = 32'h1F00_3000,
  parameter logic [15:0] BAUD_DIV  = 16'd27,
  parameter int unsigned FIFO_AW   = 4,
  parameter int unsigned TX_BURST  = 16
) (
  input  logic               HCLK,
  input  logic               HRESET,
  output logic [31:0]        HADDR,
  output logic [2:0]         HBURST,
  output logic               HMASTLOCK,
  output logic [3:0]         HPROT,
  output logic [2:0]         HSIZE,
  output logic [1:0]         HTRANS,
  output logic               HWRITE,
  output logic [31:0]        HWDATA,
  input  logic [31:0]        HRDATA,
  input  logic               HREADY,
  input  logic               HRESP,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               init_done,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned BW    = $clog2(TX_BURST + 1);

  typedef enum logic [3:0] {
    S_RESET, S_LCR_DL, S_DLL, S_DLM, S_LCR, S_FCR, S_IDLE, S_POLL, S_SEND
  } state_t;

  typedef enum logic [1:0] {PH_IDLE, PH_ADDR, PH_DATA} phase_t;

  state_t             state;
  phase_t             phase;
  logic [BW-1:0]      burst_cnt;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               req_valid;
  logic               req_write;
  logic [7:0]         req_off;
  logic [7:0]         req_data;
  logic               unused_inputs;

  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0011;
  assign HSIZE     = 3'b010;

  // Only LSR.THRE is ever consulted; the remaining read bits and HRESP carry no meaning here.
  assign unused_inputs = ^{HRESP, HRDATA[31:6], HRDATA[4:0]};

  assign in_ready   = (fifo_count != (FIFO_AW + 1)'(DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push       = in_valid && in_ready;
  assign pop        = (state == S_SEND) && (phase == PH_ADDR) && HREADY;

  // Register offset and write byte for the transfer owned by the current state.
  always_comb begin
    req_valid = 1'b1;
    req_write = 1'b1;
    req_off   = 8'h00;
    req_data  = 8'h00;
    unique case (state)
      S_LCR_DL: begin req_off = 8'h0C; req_data = 8'h83; end
      S_DLL:    req_data = BAUD_DIV[7:0];
      S_DLM:    begin req_off = 8'h04; req_data = BAUD_DIV[15:8]; end
      S_LCR:    begin req_off = 8'h0C; req_data = 8'h03; end
      S_FCR:    begin req_off = 8'h08; req_data = 8'h07; end
      S_POLL:   begin req_off = 8'h14; req_write = 1'b0; end
      S_SEND:   req_data = mem[rd_ptr];
      default:  req_valid = 1'b0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (FIFO_AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (FIFO_AW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Each state owns one single transfer; phase tracks address/data of that transfer.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= S_RESET;
      phase     <= PH_IDLE;
      HTRANS    <= 2'b00;
      HADDR     <= UART_BASE;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      init_done <= 1'b0;
      burst_cnt <= '0;
    end else begin
      unique case (phase)
        PH_IDLE: begin
          if (state == S_RESET) begin
            state <= S_LCR_DL;
          end else if (state == S_IDLE) begin
            if (!fifo_empty) state <= S_POLL;
          end else if (req_valid && HREADY) begin
            HTRANS <= 2'b10;
            HADDR  <= UART_BASE + {24'b0, req_off};
            HWRITE <= req_write;
            phase  <= PH_ADDR;
          end
        end
        PH_ADDR: begin
          if (HREADY) begin
            HTRANS <= 2'b00;
            phase  <= PH_DATA;
            if (req_write) HWDATA <= {24'b0, req_data};
            if (state == S_SEND) burst_cnt <= burst_cnt - BW'(1);
          end
        end
        PH_DATA: begin
          if (HREADY) begin
            phase <= PH_IDLE;
            unique case (state)
              S_LCR_DL: state <= S_DLL;
              S_DLL:    state <= S_DLM;
              S_DLM:    state <= S_LCR;
              S_LCR:    state <= S_FCR;
              S_FCR:    begin state <= S_IDLE; init_done <= 1'b1; end
              S_POLL: begin
                if (HRDATA[5]) begin
                  burst_cnt <= BW'(TX_BURST);
                  state     <= S_SEND;
                end
              end
              S_SEND: begin
                if (fifo_empty)             state <= S_IDLE;
                else if (burst_cnt == '0)   state <= S_POLL;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_ahb_lite_uart_console.sv
// Bench for mfp_ahb_lite_uart_console: AHB slave model with wait states and an LSR value
// queue, transaction log, and a stream checker derived from the console's transmit rules.
module tb_mfp_ahb_lite_uart_console;

  localparam logic [31:0] BASE = 32'h1F00_3000;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        init_done;
  logic [4:0]  fifo_count;

  mfp_ahb_lite_uart_console #(
    .UART_BASE (BASE),
    .BAUD_DIV  (16'd27),
    .FIFO_AW   (4),
    .TX_BURST  (16)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HADDR      (HADDR),
    .HBURST     (HBURST),
    .HMASTLOCK  (HMASTLOCK),
    .HPROT      (HPROT),
    .HSIZE      (HSIZE),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .init_done  (init_done),
    .fifo_count (fifo_count)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
  } txn_t;

  txn_t        log_q[$];
  logic [7:0]  acc_q[$];
  logic [7:0]  lsr_q[$];
  logic [7:0]  lsr_dflt;
  int unsigned ws;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Slave: each accepted address phase is followed by ws wait cycles, then completion.
  logic        dp;
  logic        dp_wr;
  logic [31:0] dp_addr;
  int unsigned wleft;
  int unsigned thr_addr_cnt;
  logic [7:0]  rd_byte;
  logic [31:0] rd_rand;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp           <= 1'b0;
      dp_wr        <= 1'b0;
      dp_addr      <= '0;
      HREADY       <= 1'b1;
      HRDATA       <= '0;
      wleft        <= 0;
      thr_addr_cnt <= 0;
    end else begin
      if (dp && HREADY) begin
        log_q.push_back('{addr: dp_addr, data: (dp_wr ? HWDATA : HRDATA), wr: dp_wr});
        dp <= 1'b0;
      end
      if (HTRANS == 2'b10 && HREADY) begin
        dp      <= 1'b1;
        dp_addr <= HADDR;
        dp_wr   <= HWRITE;
        wleft   <= ws;
        HREADY  <= (ws == 0);
        if (HWRITE && HADDR == BASE) thr_addr_cnt <= thr_addr_cnt + 1;
        if (!HWRITE) begin
          rd_byte = (lsr_q.size() > 0) ? lsr_q.pop_front() : lsr_dflt;
          rd_rand = $urandom;
          HRDATA <= {rd_rand[31:8], rd_byte};
        end
      end else if (dp && !HREADY) begin
        if (wleft <= 1) HREADY <= 1'b1;
        wleft <= wleft - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_log(input int unsigned n, input string tag);
    int unsigned k = 0;
    while (log_q.size() < n && k < 5000) begin @(negedge HCLK); k++; end
    check({tag, "_timeout"}, 32'(log_q.size() >= n), 32'd1);
  endtask

  function automatic int unsigned thr_since(input int unsigned mark);
    int unsigned n = 0;
    for (int unsigned i = mark; i < log_q.size(); i++) if (log_q[i].wr) n++;
    return n;
  endfunction

  task automatic wait_thr(input int unsigned mark, input int unsigned n, input string tag);
    int unsigned k = 0;
    while (thr_since(mark) < n && k < 20000) begin @(negedge HCLK); k++; end
    check({tag, "_timeout"}, 32'(thr_since(mark) >= n), 32'd1);
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic push_byte(input logic [7:0] b);
    int unsigned k = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && k < 5000) begin @(negedge HCLK); k++; end
    if (!in_ready) check("push_timeout", 32'd0, 32'd1);
    @(negedge HCLK);
    acc_q.push_back(b);
    in_valid = 1'b0;
  endtask

  task automatic check_init(input string tag);
    logic [7:0] offs [5] = '{8'h0C, 8'h00, 8'h04, 8'h0C, 8'h08};
    logic [7:0] vals [5] = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'h07};
    wait_log(4, {tag, "_w4"});
    check({tag, "_done_low"}, 32'(init_done), 32'd0);
    wait_log(5, {tag, "_w5"});
    @(negedge HCLK);
    check({tag, "_done_high"}, 32'(init_done), 32'd1);
    for (int unsigned i = 0; i < 5; i++) begin
      check($sformatf("%s_addr%0d", tag, i), log_q[i].addr, BASE + {24'b0, offs[i]});
      check($sformatf("%s_data%0d", tag, i), log_q[i].data, {24'b0, vals[i]});
      check($sformatf("%s_wr%0d", tag, i), 32'(log_q[i].wr), 32'd1);
    end
  endtask

  // A THR write is legal only after an LSR read with THRE set, at most 16 per such read;
  // THR bytes must match the accepted bytes in order.
  task automatic check_stream(input int unsigned mark, input string tag,
                              output int unsigned reads, output int unsigned nb,
                              output int unsigned b0, output int unsigned b1);
    int unsigned budget = 0;
    logic [7:0]  exp;
    reads = 0; nb = 0; b0 = 0; b1 = 0;
    for (int unsigned i = mark; i < log_q.size(); i++) begin
      if (!log_q[i].wr) begin
        check({tag, "_lsr_addr"}, log_q[i].addr, BASE + 32'h14);
        reads++;
        budget = log_q[i].data[5] ? 16 : 0;
        if (log_q[i].data[5]) nb++;
      end else begin
        check({tag, "_thr_addr"}, log_q[i].addr, BASE);
        check({tag, "_thr_allowed"}, 32'(budget != 0), 32'd1);
        if (budget != 0) budget--;
        if (nb == 1) b0++;
        else if (nb == 2) b1++;
        if (acc_q.size() > 0) begin
          exp = acc_q.pop_front();
          check({tag, "_thr_data"}, log_q[i].data, {24'b0, exp});
        end else begin
          check({tag, "_thr_extra"}, log_q[i].data, 32'hDEAD_BEEF);
        end
      end
    end
    check({tag, "_all_sent"}, 32'(acc_q.size()), 32'd0);
    acc_q.delete();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned mark, reads, nb, b0, b1, thr0, k;
    HRESET   = 1'b1;
    HRESP    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    ws       = 2;
    lsr_dflt = 8'h60;
    repeat (3) @(negedge HCLK);

    check("rst_htrans", 32'(HTRANS), 32'd0);
    check("rst_haddr", HADDR, BASE);
    check("rst_hwrite", 32'(HWRITE), 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("const_hburst", 32'(HBURST), 32'd0);
    check("const_hprot", 32'(HPROT), 32'd3);
    check("const_hsize", 32'(HSIZE), 32'd2);
    HRESET = 1'b0;

    check_init("init");

    // Three bytes, THRE already set.
    ws = 1;
    repeat (5) @(negedge HCLK);
    mark = log_q.size();
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    wait_thr(mark, 3, "abc");
    repeat (10) @(negedge HCLK);
    check("abc_htrans_idle", 32'(HTRANS), 32'd0);
    check("abc_fifo_empty", 32'(fifo_count), 32'd0);
    check_stream(mark, "abc", reads, nb, b0, b1);
    check("abc_reads", reads, 32'd1);
    check("abc_burst", b0, 32'd3);

    // THRE low three times before going high.
    mark = log_q.size();
    lsr_q = '{8'h00, 8'h00, 8'h00, 8'h20};
    lsr_dflt = 8'h20;
    push_byte(8'h5A);
    wait_thr(mark, 1, "poll");
    repeat (10) @(negedge HCLK);
    check_stream(mark, "poll", reads, nb, b0, b1);
    check("poll_reads", reads, 32'd4);
    check("poll_burst", b0, 32'd1);

    // Fill the FIFO while THRE stays low, then release and send 20 bytes.
    mark = log_q.size();
    lsr_dflt = 8'h00;
    for (int i = 0; i < 16; i++) push_byte(8'(8'h30 + i));
    check("fill_count", 32'(fifo_count), 32'd16);
    check("fill_ready", 32'(in_ready), 32'd0);
    in_data  = 8'h40;
    in_valid = 1'b1;
    thr0 = thr_addr_cnt;
    repeat (30) @(negedge HCLK);
    check("held_ready", 32'(in_ready), 32'd0);
    check("held_count", 32'(fifo_count), 32'd16);
    check("held_no_thr", thr_addr_cnt, thr0);
    lsr_dflt = 8'h20;
    k = 0;
    while (!in_ready && k < 2000) begin @(negedge HCLK); k++; end
    check("held_until_pop", thr_addr_cnt, thr0 + 1);
    @(negedge HCLK);
    acc_q.push_back(8'h40);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(8'(8'h41 + i));
    wait_thr(mark, 20, "burst");
    repeat (10) @(negedge HCLK);
    check_stream(mark, "burst", reads, nb, b0, b1);
    check("burst_count", nb, 32'd2);
    check("burst_first", b0, 32'd16);
    check("burst_second", b1, 32'd4);

    // Random bytes, gaps, wait states and LSR values.
    mark = log_q.size();
    ws = $urandom_range(0, 3);
    for (int i = 0; i < 8; i++) lsr_q.push_back(8'($urandom));
    lsr_dflt = 8'h20;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge HCLK);
      push_byte(8'($urandom));
    end
    wait_thr(mark, 30, "rand");
    repeat (10) @(negedge HCLK);
    check_stream(mark, "rand", reads, nb, b0, b1);
    check("rand_fifo_empty", 32'(fifo_count), 32'd0);

    // Reset in the data phase of a THR write.
    ws = 4;
    lsr_q.delete();
    lsr_dflt = 8'h20;
    push_byte(8'h77); push_byte(8'h78);
    k = 0;
    while (!(dp && dp_wr && dp_addr == BASE && !HREADY) && k < 2000) begin
      @(negedge HCLK); k++;
    end
    check("mid_reset_reached", 32'(dp && dp_wr && !HREADY), 32'd1);
    #1 HRESET = 1'b1;
    #1;
    check("mid_rst_htrans", 32'(HTRANS), 32'd0);
    check("mid_rst_haddr", HADDR, BASE);
    check("mid_rst_hwrite", 32'(HWRITE), 32'd0);
    check("mid_rst_hwdata", HWDATA, 32'd0);
    check("mid_rst_init_done", 32'(init_done), 32'd0);
    check("mid_rst_fifo_count", 32'(fifo_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    log_q.delete();
    acc_q.delete();
    ws = 2;
    @(negedge HCLK);
    HRESET = 1'b0;
    check_init("reinit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
